ws2812_chain_driver: RTL and testbench

WS2812_CHAIN_DRIVER -- requirements
Module: ws2812_chain_driver

---
 rtl/ws2812_chain_driver.sv | 177 +++++++++++++++++
 tb/tb_ws2812_chain_driver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain_driver.sv
// WS2812 serial LED chain driver: streams NUM_LEDS 24-bit GRB pixels with
// per-bit high/low timing, followed by a TRES-cycle latch interval.
module ws2812_chain_driver #(
  parameter int NUM_LEDS = 8,
  parameter int T0H      = 16,
  parameter int T1H      = 32,
  parameter int TBIT     = 50,
  parameter int TRES     = 2000,
  parameter bit INVERT   = 1'b0
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        q,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int CMAX = (TBIT > TRES) ? TBIT : TRES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int PW   = $clog2(NUM_LEDS + 1);

  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] TRES_LAST = CW'(TRES - 1);
  localparam logic [CW-1:0] T0H_C     = CW'(T0H);
  localparam logic [CW-1:0] T1H_C     = CW'(T1H);
  localparam logic [PW-1:0] NUM_C     = PW'(NUM_LEDS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    BIT_HI,
    BIT_LO,
    LATCH
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        q_q, q_d;

  logic [CW-1:0] hi_len;
  logic [CW-1:0] cnt_inc;
  logic          in_bit;
  logic          bit_end;
  logic          pix_end;
  logic          more_pix;
  logic          accept;
  logic          load;

  assign hi_len   = shift_q[23] ? T1H_C : T0H_C;
  assign cnt_inc  = cnt_q + 1'b1;
  assign in_bit   = (state_q == BIT_HI) || (state_q == BIT_LO);
  assign bit_end  = in_bit && (cnt_q == TBIT_LAST);
  assign pix_end  = bit_end && (bit_idx_q == 5'd23);
  assign more_pix = pix_cnt_q < NUM_C;
  assign accept   = pix_valid && pix_ready;
  // A pixel is loaded either to begin the frame or seamlessly after bit 23.
  assign load     = ((state_q == WAIT_FIRST) && buf_full_q) ||
                    (pix_end && more_pix && buf_full_q);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = WAIT_FIRST;
      WAIT_FIRST: if (buf_full_q) state_d = BIT_HI;
      BIT_HI, BIT_LO: begin
        if (bit_end) begin
          if (!pix_end || load) state_d = BIT_HI;
          else                  state_d = LATCH;
        end else if (cnt_inc >= hi_len) begin
          state_d = BIT_LO;
        end else begin
          state_d = BIT_HI;
        end
      end
      LATCH:      if (cnt_q == TRES_LAST) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    pix_cnt_d  = pix_cnt_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;

    if (accept) begin
      buf_d      = pix_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        pix_cnt_d = '0;
      end
      BIT_HI, BIT_LO: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!pix_end) begin
            shift_d   = shift_q << 1;
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LATCH: cnt_d = (cnt_q == TRES_LAST) ? '0 : cnt_inc;
      default: ;
    endcase

    if (load) begin
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      cnt_d      = '0;
      bit_idx_d  = '0;
      pix_cnt_d  = pix_cnt_q + 1'b1;
    end

    // Anything that slipped into the buffer on the way into LATCH is dropped.
    if ((state_d == LATCH) && (state_q != LATCH)) begin
      buf_full_d = 1'b0;
      cnt_d      = '0;
    end

    q_d = (state_d == BIT_HI) ^ INVERT;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      pix_cnt_q  <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      q_q        <= INVERT;
    end else begin
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      pix_cnt_q  <= pix_cnt_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      q_q        <= q_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    pix_ready = busy && !buf_full_q && (state_q != LATCH);
    done      = (state_q == LATCH) && (cnt_q == TRES_LAST);
    underrun  = pix_end && more_pix && !buf_full_q;
    q         = q_q;
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Directed bench for ws2812_chain_driver: single pixel, inverted pin, ignored
// start, mid-bit reset, seamless back-to-back pixels and underrun truncation.
module tb_ws2812_chain_driver;

  localparam int TBIT = 50;
  localparam int T0H  = 16;
  localparam int T1H  = 32;
  localparam int TRES = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_a = 1'b0, start_a = 1'b0, valid_a = 1'b0;
  logic [23:0] data_a = '0;
  logic        ready_a, q_a, busy_a, done_a, und_a;
  logic        ready_ai, q_ai, busy_ai, done_ai, und_ai;

  logic        res_b = 1'b0, start_b = 1'b0, valid_b = 1'b0;
  logic [23:0] data_b = '0;
  logic        ready_b, q_b, busy_b, done_b, und_b;

  logic        res_c = 1'b0, start_c = 1'b0, valid_c = 1'b0;
  logic [23:0] data_c = '0;
  logic        ready_c, q_c, busy_c, done_c, und_c;

  int n_vec = 0;
  int n_err = 0;

  ws2812_chain_driver #(.NUM_LEDS(1)) u_a (
    .clk(clk), .res(res_a), .start(start_a), .pix_data(data_a), .pix_valid(valid_a),
    .pix_ready(ready_a), .q(q_a), .busy(busy_a), .done(done_a), .underrun(und_a));

  ws2812_chain_driver #(.NUM_LEDS(1), .INVERT(1'b1)) u_ai (
    .clk(clk), .res(res_a), .start(start_a), .pix_data(data_a), .pix_valid(valid_a),
    .pix_ready(ready_ai), .q(q_ai), .busy(busy_ai), .done(done_ai), .underrun(und_ai));

  ws2812_chain_driver #(.NUM_LEDS(2)) u_b (
    .clk(clk), .res(res_b), .start(start_b), .pix_data(data_b), .pix_valid(valid_b),
    .pix_ready(ready_b), .q(q_b), .busy(busy_b), .done(done_b), .underrun(und_b));

  ws2812_chain_driver #(.NUM_LEDS(3)) u_c (
    .clk(clk), .res(res_c), .start(start_c), .pix_data(data_c), .pix_valid(valid_c),
    .pix_ready(ready_c), .q(q_c), .busy(busy_c), .done(done_c), .underrun(und_c));

  // Reference line level at cycle k after the first BIT_HI cycle.
  function automatic logic exp_q(input logic [23:0] px [3], input int npix, input int k);
    int bn;
    int c;
    logic v;
    bn = k / TBIT;
    c  = k % TBIT;
    if (bn >= npix * 24) return 1'b0;
    v = px[bn / 24][23 - (bn % 24)];
    return (c < (v ? T1H : T0H));
  endfunction

  task automatic test_reset;
    @(negedge clk);
    n_vec++;
    if ({q_a, q_ai, busy_a, ready_a, done_a, und_a, busy_ai, ready_ai, done_ai, und_ai} !== 10'b0100000000) begin
      n_err++;
      $display("FAIL reset_a: got %b expected 0100000000",
               {q_a, q_ai, busy_a, ready_a, done_a, und_a, busy_ai, ready_ai, done_ai, und_ai});
    end
    n_vec++;
    if ({q_b, busy_b, ready_b, done_b, und_b, q_c, busy_c, ready_c, done_c, und_c} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_bc: got %b expected 0000000000",
               {q_b, busy_b, ready_b, done_b, und_b, q_c, busy_c, ready_c, done_c, und_c});
    end
    res_a = 1'b1; res_b = 1'b1; res_c = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy_a, busy_b, busy_c, q_a, q_ai} !== 5'b00001) begin
      n_err++;
      $display("FAIL idle_after_release: got %b expected 00001", {busy_a, busy_b, busy_c, q_a, q_ai});
    end
  endtask

  task automatic test_frame_a(input logic [23:0] p, input bit pulse_start, input int abort_k,
                              input string name);
    logic [23:0] px [3];
    int total, bad, first_bad, last_k;
    logic eq, ed;
    px[0] = p; px[1] = '0; px[2] = '0;
    total = 24 * TBIT + TRES;
    bad = 0; first_bad = -1;
    last_k = (abort_k >= 0) ? abort_k : total - 1;

    @(negedge clk);
    data_a = p; valid_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_vec++;
    if ({busy_a, ready_a, q_a, q_ai} !== 4'b1101) begin
      n_err++;
      $display("FAIL %s wait_first: busy/ready/q/qi=%b expected 1101", name, {busy_a, ready_a, q_a, q_ai});
    end
    @(negedge clk);
    valid_a = 1'b0;
    n_vec++;
    if (ready_a !== 1'b0) begin
      n_err++;
      $display("FAIL %s buf_full_ready: got %b expected 0", name, ready_a);
    end

    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      eq = exp_q(px, 1, k);
      ed = (k == total - 1);
      if (q_a !== eq || q_ai !== ~eq || done_a !== ed || und_a !== 1'b0 || busy_a !== 1'b1 ||
          {busy_ai, done_ai, und_ai, ready_ai} !== {busy_a, done_a, und_a, ready_a}) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
      if (pulse_start) start_a = (k == 5 || k == 1300);
    end
    start_a = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s waveform: %0d bad cycles, first at %0d (q=%b qi=%b done=%b), expected 0 bad",
               name, bad, first_bad, q_a, q_ai, done_a);
    end

    if (abort_k >= 0) begin
      res_a = 1'b0;
      #1;
      n_vec++;
      if ({q_a, q_ai, busy_a, ready_a, done_a, und_a} !== 6'b010000) begin
        n_err++;
        $display("FAIL %s async_reset: got %b expected 010000", name, {q_a, q_ai, busy_a, ready_a, done_a, und_a});
      end
      @(negedge clk);
      res_a = 1'b1;
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy_a !== 1'b0 || q_a !== 1'b0 || done_a !== 1'b0 || und_a !== 1'b0) bad++;
      end
      n_vec++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL %s idle_after_abort: %0d bad cycles expected 0", name, bad);
      end
    end else begin
      @(negedge clk);
      n_vec++;
      if ({busy_a, q_a, q_ai, done_a} !== 4'b0010) begin
        n_err++;
        $display("FAIL %s after_done: busy/q/qi/done=%b expected 0010", name, {busy_a, q_a, q_ai, done_a});
      end
      if (pulse_start) begin
        bad = 0;
        repeat (60) begin
          @(negedge clk);
          if (busy_a !== 1'b0 || q_a !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
          n_err++;
          $display("FAIL %s second_frame: %0d busy cycles expected 0", name, bad);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] px [3];
    int total;
    px[0] = 24'hFFFFFF; px[1] = 24'h000000; px[2] = '0;
    total = 2 * 24 * TBIT + TRES;

    @(negedge clk);
    start_b = 1'b1;
    fork
      begin : feed
        int i;
        bit acc;
        i = 0; acc = 1'b0;
        valid_b = 1'b1; data_b = px[0];
        for (int g = 0; g < 200 && i < 2; g++) begin
          @(negedge clk);
          if (acc) begin
            i++;
            if (i < 2) data_b = px[i];
            else       valid_b = 1'b0;
          end
          acc = ready_b && valid_b;
        end
        valid_b = 1'b0;
        n_vec++;
        if (i != 2) begin
          n_err++;
          $display("FAIL b2b feed: %0d pixels accepted expected 2", i);
        end
      end
      begin : chk
        int bad, first_bad;
        logic eq, ed;
        bad = 0; first_bad = -1;
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        for (int k = 0; k < total; k++) begin
          @(negedge clk);
          eq = exp_q(px, 2, k);
          ed = (k == total - 1);
          if (q_b !== eq || done_b !== ed || und_b !== 1'b0 || busy_b !== 1'b1) begin
            if (bad == 0) first_bad = k;
            bad++;
          end
        end
        n_vec++;
        if (bad != 0) begin
          n_err++;
          $display("FAIL b2b waveform: %0d bad cycles, first at %0d, expected 0 bad", bad, first_bad);
        end
        @(negedge clk);
        n_vec++;
        if ({busy_b, q_b, done_b} !== 3'b000) begin
          n_err++;
          $display("FAIL b2b after_done: busy/q/done=%b expected 000", {busy_b, q_b, done_b});
        end
      end
    join
  endtask

  task automatic test_underrun;
    logic [23:0] px [3];
    int total, bad, first_bad, n_und, n_done;
    logic eq, er;
    px[0] = 24'h5A0F81; px[1] = '0; px[2] = '0;
    total = 24 * TBIT + TRES;
    bad = 0; first_bad = -1; n_und = 0; n_done = 0;

    @(negedge clk);
    data_c = px[0]; valid_c = 1'b1; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    @(negedge clk);
    valid_c = 1'b0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      eq = exp_q(px, 1, k);
      er = (k < 24 * TBIT);
      if (und_c === 1'b1) n_und++;
      if (done_c === 1'b1) n_done++;
      if (q_c !== eq || ready_c !== er || und_c !== (k == 24 * TBIT - 1) ||
          done_c !== (k == total - 1) || busy_c !== 1'b1) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
      if (k == 24 * TBIT) begin
        data_c = 24'hFFFFFF; valid_c = 1'b1;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL underrun waveform: %0d bad cycles, first at %0d, expected 0 bad", bad, first_bad);
    end
    n_vec++;
    if (n_und != 1) begin
      n_err++;
      $display("FAIL underrun pulses: got %0d expected 1", n_und);
    end
    n_vec++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL underrun done_pulses: got %0d expected 1", n_done);
    end
    @(negedge clk);
    n_vec++;
    if ({busy_c, ready_c, q_c} !== 3'b000) begin
      n_err++;
      $display("FAIL underrun after_done: busy/ready/q=%b expected 000", {busy_c, ready_c, q_c});
    end
    valid_c = 1'b0;
  endtask

  initial begin
    test_reset;
    test_frame_a(24'h800000, 1'b0, -1, "single_pixel");
    test_frame_a(24'h800000, 1'b1, -1, "start_ignored");
    test_frame_a(24'h800000, 1'b0, 5 * TBIT + 10, "reset_mid_bit");
    test_frame_a(24'hA5C30F, 1'b0, -1, "post_reset");
    test_back_to_back;
    test_underrun;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
